// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the responder state encodings, the store/load encodings of the
// request write-enable bit, and the byte-offset width that separates a byte
// address from its word index.
package dmem_responder_pkg;

   // Responder states
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   // Encodings of req_we
   localparam logic WE_LOAD  = 1'b0;
   localparam logic WE_STORE = 1'b1;

   // Byte-offset bits below the word index in a byte address
   localparam int unsigned BYTE_OFF_W = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word array.
// Ports:
//   clk   - clock, writes and reads happen on the rising edge
//   en    - access enable; with we=0 the read register is updated
//   we    - write enable (only meaningful when en=1)
//   idx   - word index
//   wdata - write data
//   rdata - registered read data, holds its value while en=0
module dmem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = 8
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // NOTE: the storage and its read register carry no reset, so the array can
   // map onto block RAM; contents after power-up are simply undefined.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[idx] <= wdata;
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage.
// Accepts one load/store request at a time, performs the access LATENCY
// cycles after acceptance and presents the result until it is taken.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   req_valid / req_ready  - request handshake (req_ready high only in IDLE)
//   req_we, req_addr,
//   req_wdata              - store flag, byte address, store data
//   resp_valid / resp_ready- response handshake
//   resp_rdata, resp_err   - load data (0 for stores/errors), access error
//   busy                   - high whenever a request is in flight
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2,   // 1..15
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy
);

   localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
   localparam int unsigned WIDX_W = ADDR_W - BYTE_OFF_W;
   localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH_WORDS);

   state_t            state;
   logic [3:0]        cnt;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;
   logic              load_ok;     // response carries array read data
   logic [31:0]       arr_rdata;

   // Access checks on the latched address; the full word index is compared
   // so addresses beyond the array never alias onto it.
   logic [WIDX_W-1:0] word_idx;
   logic              access_err;
   logic              do_access;
   logic              arr_en;
   logic              arr_we;

   assign word_idx   = lat_addr[ADDR_W-1:BYTE_OFF_W];
   assign access_err = (lat_addr[BYTE_OFF_W-1:0] != '0) || (word_idx >= DEPTH_LIM);
   assign do_access  = (state == ST_WAIT) && (cnt == 4'd0);
   assign arr_en     = do_access && !access_err;
   assign arr_we     = arr_en && (lat_we == WE_STORE);

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (arr_en),
      .we    (arr_we),
      .idx   (word_idx[IDX_W-1:0]),
      .wdata (lat_wdata),
      .rdata (arr_rdata)
   );

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= 4'd0;
         resp_err <= 1'b0;
         load_ok  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // req_ready is implied by being in IDLE
               if (req_valid) begin
                  lat_we    <= req_we;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  cnt       <= 4'(LATENCY - 1);
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd0) begin
                  resp_err <= access_err;
                  load_ok  <= !access_err && (lat_we == WE_LOAD);
                  state    <= ST_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_err <= 1'b0;
                  load_ok  <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   // The array read register is only refreshed by an access, so it holds
   // steady for the whole RESP phase.
   assign resp_rdata = load_ok ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder.
// Three instances (LATENCY 2, 1, 15) share clock and reset. A transaction-level
// model predicts, edge by edge, when each instance is idle, when its response
// is due and what it must carry; one compare process checks every cycle.
// Directed tests pin the model with hand-computed literals.
module tb_dmem_responder;

   localparam int NI    = 3;
   localparam int DEPTH = 256;
   localparam int AW    = 32;

   function automatic int lat_of(input int k);
      case (k)
         0:       return 2;
         1:       return 1;
         default: return 15;
      endcase
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          req_valid  [NI];
   logic          req_ready  [NI];
   logic          req_we     [NI];
   logic [AW-1:0] req_addr   [NI];
   logic [31:0]   req_wdata  [NI];
   logic          resp_valid [NI];
   logic          resp_ready [NI];
   logic [31:0]   resp_rdata [NI];
   logic          resp_err   [NI];
   logic          busy       [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dmem_responder #(
         .DEPTH_WORDS (DEPTH),
         .LATENCY     ((g == 0) ? 2 : ((g == 1) ? 1 : 15)),
         .ADDR_W      (AW)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_we     (req_we[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_rdata (resp_rdata[g]),
         .resp_err   (resp_err[g]),
         .busy       (busy[g])
      );
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // An instance is idle unless it holds a pending request (due at a known
   // edge) or an undelivered response.
   int          ecnt = 0;
   bit          m_pend [NI];
   bit          m_resp [NI];
   int          m_due  [NI];
   bit          m_we   [NI];
   logic [31:0] m_addr [NI];
   logic [31:0] m_wdat [NI];
   logic [31:0] m_rdat [NI];
   bit          m_err  [NI];
   logic [31:0] mmem   [NI][DEPTH];

   always @(posedge clk) begin
      ecnt <= ecnt + 1;
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            m_pend[k] <= 1'b0;
            m_resp[k] <= 1'b0;
         end else if (m_resp[k]) begin
            if (resp_ready[k]) m_resp[k] <= 1'b0;
         end else if (m_pend[k]) begin
            if (ecnt == m_due[k]) begin
               m_pend[k] <= 1'b0;
               m_resp[k] <= 1'b1;
               if (m_addr[k] % 4 != 0 || m_addr[k] / 4 >= DEPTH) begin
                  m_err[k]  <= 1'b1;
                  m_rdat[k] <= 32'd0;
               end else if (m_we[k]) begin
                  mmem[k][m_addr[k] / 4] <= m_wdat[k];
                  m_err[k]  <= 1'b0;
                  m_rdat[k] <= 32'd0;
               end else begin
                  m_err[k]  <= 1'b0;
                  m_rdat[k] <= mmem[k][m_addr[k] / 4];
               end
            end
         end else if (req_valid[k]) begin
            m_pend[k] <= 1'b1;
            m_due[k]  <= ecnt + lat_of(k);
            m_we[k]   <= req_we[k];
            m_addr[k] <= req_addr[k];
            m_wdat[k] <= req_wdata[k];
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < NI; k++) begin
            bit idle;
            idle = !m_pend[k] && !m_resp[k];
            check($sformatf("i%0d req_ready", k), 32'(req_ready[k]), 32'(idle));
            check($sformatf("i%0d busy", k), 32'(busy[k]), 32'(!idle));
            check($sformatf("i%0d resp_valid", k), 32'(resp_valid[k]), 32'(m_resp[k]));
            if (m_resp[k]) begin
               check($sformatf("i%0d resp_rdata", k), resp_rdata[k], m_rdat[k]);
               check($sformatf("i%0d resp_err", k), 32'(resp_err[k]), 32'(m_err[k]));
            end
         end
      end
   end

   // ---------------- transaction driver ----------------
   // Called at a negedge; returns at the negedge after the response handshake.
   task automatic do_txn(input int k, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay, input bit noise,
                         output logic [31:0] rdata, output logic err, output int acc_edge);
      int n;
      req_we[k]    = we;
      req_addr[k]  = addr;
      req_wdata[k] = wdata;
      req_valid[k] = 1'b1;
      n = 0;
      while (!req_ready[k] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check($sformatf("i%0d req_ready timeout", k), 32'(n), 32'd0);
      @(posedge clk);
      @(negedge clk);
      acc_edge     = ecnt;
      req_valid[k] = 1'b0;
      n = 0;
      while (!resp_valid[k] && n < 40) begin
         resp_ready[k] = noise ? 1'($urandom_range(1)) : 1'b0;
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check($sformatf("i%0d latency", k), 32'(n), 32'(lat_of(k)));
      rdata = resp_rdata[k];
      err   = resp_err[k];
      resp_ready[k] = 1'b0;
      for (int i = 0; i < delay; i++) begin
         // requests offered while busy must be ignored
         req_valid[k] = (i < delay - 1) && (i % 2 == 0);
         req_addr[k]  = $urandom;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("i%0d hold rdata", k), resp_rdata[k], rdata);
      end
      req_valid[k]  = 1'b0;
      resp_ready[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready[k] = 1'b0;
      check($sformatf("i%0d idle after handshake", k), 32'(req_ready[k]), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] pre [DEPTH];
   logic [31:0] rd;
   logic        er;
   int          acc, prev_acc;
   logic [31:0] vals [4];

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < NI; k++) begin
         req_valid[k]  = 1'b0;
         req_we[k]     = 1'b0;
         req_addr[k]   = '0;
         req_wdata[k]  = '0;
         resp_ready[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // reset state
      for (int k = 0; k < NI; k++) begin
         check($sformatf("i%0d reset req_ready", k), 32'(req_ready[k]), 32'd1);
         check($sformatf("i%0d reset resp_valid", k), 32'(resp_valid[k]), 32'd0);
         check($sformatf("i%0d reset busy", k), 32'(busy[k]), 32'd0);
         check($sformatf("i%0d reset rdata", k), resp_rdata[k], 32'd0);
         check($sformatf("i%0d reset err", k), 32'(resp_err[k]), 32'd0);
      end

      // preload instance 0 through the port
      for (int i = 0; i < DEPTH; i++) begin
         pre[i] = (i == 8) ? 32'hAAAA_AAAA : $urandom;
         do_txn(0, 1'b1, 32'(i * 4), pre[i], 0, 1'b0, rd, er, acc);
      end

      // store then load
      do_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, rd, er, acc);
      check("store rdata", rd, 32'd0);
      check("store err", 32'(er), 32'd0);
      do_txn(0, 1'b0, 32'h10, 32'd0, 0, 1'b0, rd, er, acc);
      check("load 0x10", rd, 32'hDEAD_BEEF);
      check("load 0x10 err", 32'(er), 32'd0);

      // backpressure: response held 5 cycles with request pulses ignored
      do_txn(0, 1'b0, 32'h3F8, 32'd0, 5, 1'b1, rd, er, acc);
      check("backpressure load", rd, pre[254]);

      // errors
      do_txn(0, 1'b0, 32'h12, 32'd0, 0, 1'b0, rd, er, acc);
      check("misaligned err", 32'(er), 32'd1);
      check("misaligned rdata", rd, 32'd0);
      do_txn(0, 1'b1, 32'h400, 32'hFFFF_FFFF, 0, 1'b0, rd, er, acc);
      check("out-of-range store err", 32'(er), 32'd1);
      do_txn(0, 1'b0, 32'h3FC, 32'd0, 0, 1'b0, rd, er, acc);
      check("last word intact", rd, pre[255]);
      check("last word err", 32'(er), 32'd0);

      // reset one cycle after acceptance abandons the store
      req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h1234_5678;
      req_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset in WAIT busy", 32'(busy[0]), 32'd0);
      do_txn(0, 1'b0, 32'h20, 32'd0, 0, 1'b0, rd, er, acc);
      check("abandoned store", rd, 32'hAAAA_AAAA);

      // reset coincident with a request: not accepted
      req_we[0] = 1'b1; req_addr[0] = 32'h24; req_wdata[0] = 32'h0BAD_0BAD;
      req_valid[0] = 1'b1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      rst_n = 1'b1;
      check("reset vs handshake busy", 32'(busy[0]), 32'd0);
      do_txn(0, 1'b0, 32'h24, 32'd0, 0, 1'b0, rd, er, acc);
      check("reset vs handshake data", rd, pre[9]);

      // reset in RESP: store already committed
      req_we[0] = 1'b1; req_addr[0] = 32'h30; req_wdata[0] = 32'h5555_0055;
      req_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reach RESP", 32'(resp_valid[0]), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset in RESP drops valid", 32'(resp_valid[0]), 32'd0);
      do_txn(0, 1'b0, 32'h30, 32'd0, 0, 1'b0, rd, er, acc);
      check("committed store", rd, 32'h5555_0055);

      // randomized traffic, judged by the model
      for (int t = 0; t < 200; t++) begin
         logic [31:0] a;
         int sel;
         sel = $urandom_range(7);
         if (sel == 0)      a = 32'($urandom_range(DEPTH - 1) * 4 + $urandom_range(3, 1));
         else if (sel == 1) a = 32'h400 + 32'($urandom_range(63) * 4);
         else               a = 32'($urandom_range(DEPTH - 1) * 4);
         do_txn(0, 1'($urandom_range(1)), a, $urandom, $urandom_range(3), 1'b1, rd, er, acc);
      end

      // latency sweep: LATENCY=1 and 15, back-to-back loads
      for (int k = 1; k < NI; k++) begin
         for (int j = 0; j < 4; j++) begin
            vals[j] = $urandom;
            do_txn(k, 1'b1, 32'(32'h40 + j * 4), vals[j], 0, 1'b0, rd, er, acc);
         end
         for (int j = 0; j < 4; j++) begin
            prev_acc = acc;
            do_txn(k, 1'b0, 32'(32'h40 + j * 4), 32'd0, 0, 1'b0, rd, er, acc);
            check($sformatf("i%0d sweep load %0d", k, j), rd, vals[j]);
            check($sformatf("i%0d spacing %0d", k, j), 32'(acc - prev_acc), 32'(lat_of(k) + 2));
         end
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
